// File: rtl/noc_eject_checker_pkg.sv
// noc_eject_checker_pkg: flit layout, marker constants, field helpers and FSM encoding
package noc_eject_checker_pkg;
  localparam int NOC_DATA_WIDTH = 32;
  localparam int NOC_ID_X_WIDTH = 3;
  localparam int NOC_ID_Y_WIDTH = 3;
  localparam int NOC_ID_WIDTH = NOC_ID_X_WIDTH + NOC_ID_Y_WIDTH;
  localparam int NOC_POINT_H = 28;
  localparam int NOC_SOURCE_POINT = NOC_POINT_H - NOC_ID_WIDTH;
  localparam int AXI_LEN_POINT = NOC_SOURCE_POINT - NOC_ID_WIDTH;
  localparam int NOC_POINT_E = 12;
  localparam int MARK_W = 4;
  localparam logic [MARK_W-1:0] NOC_HEAD_H = 4'hA;
  localparam logic [MARK_W-1:0] NOC_TAIL_H = 4'h5;
  localparam logic [MARK_W-1:0] NOC_HEAD_E = 4'h3;
  localparam logic [MARK_W-1:0] NOC_TAIL_E = 4'hC;
  typedef enum logic [1:0] {WAIT_HEAD = 2'd0, BODY = 2'd1, DROP = 2'd2} state_t;
  function automatic logic [MARK_W-1:0] mark_h(input logic [NOC_DATA_WIDTH-1:0] f);
    return f[NOC_DATA_WIDTH-1:NOC_POINT_H];
  endfunction
  function automatic logic [MARK_W-1:0] mark_e(input logic [NOC_DATA_WIDTH-1:0] f);
    return f[AXI_LEN_POINT-1:NOC_POINT_E];
  endfunction
  function automatic logic [NOC_ID_WIDTH-1:0] src_id(input logic [NOC_DATA_WIDTH-1:0] f);
    return f[NOC_POINT_H-1:NOC_SOURCE_POINT];
  endfunction
  function automatic logic [NOC_ID_WIDTH-1:0] dst_id(input logic [NOC_DATA_WIDTH-1:0] f);
    return f[NOC_SOURCE_POINT-1:AXI_LEN_POINT];
  endfunction
endpackage

// File: rtl/noc_eject_checker_if.sv
// noc_eject_checker_if: router-side ingress and node-side egress flit channels
interface noc_eject_checker_if;
  import noc_eject_checker_pkg::*;
  logic in_valid, in_ready, in_is_header, in_is_tail;
  logic [NOC_DATA_WIDTH-1:0] in_flit, out_flit;
  logic out_valid, out_ready, out_sop, out_eop;
  logic [NOC_ID_X_WIDTH-1:0] out_src_x;
  logic [NOC_ID_Y_WIDTH-1:0] out_src_y;
  modport master(
    output in_valid, in_flit, in_is_header, in_is_tail, out_ready,
    input in_ready, out_valid, out_flit, out_sop, out_eop, out_src_x, out_src_y
  );
  modport slave(
    input in_valid, in_flit, in_is_header, in_is_tail, out_ready,
    output in_ready, out_valid, out_flit, out_sop, out_eop, out_src_x, out_src_y
  );
endinterface

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock FIFO without bypass, sync active-high reset
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  assign dout = r_mem[r_rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // storage array, written on push only
  always_ff @(posedge clk)
    if (push) r_mem[r_wp] <= din;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      count <= '0;
    end else begin
      r_wp <= r_wp + AW'(push);
      r_rp <= r_rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/noc_eject_checker.sv
// noc_eject_checker: ejection FIFO that forwards well-formed local packets and drops the rest
module noc_eject_checker
  import noc_eject_checker_pkg::*;
#(
  parameter logic [NOC_ID_X_WIDTH-1:0] X_ID = '0,
  parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID = '0,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BODY = 16
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  noc_eject_checker_if.slave        bus,
  output logic [15:0]               pkt_count,
  output logic [7:0]                err_count,
  output logic                      err_dest,
  output logic                      err_frame,
  output logic                      err_len
);
  localparam int BW = $clog2(MAX_BODY + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic w_push, w_pop, w_full, w_empty, w_hdr, w_tail;
  logic [CW-1:0] w_count;
  logic [NOC_DATA_WIDTH-1:0] w_flit;
  logic w_head_mk, w_tail_ok, w_dest_ok, w_good_head, w_body_full;
  logic w_fwd, w_hs, w_eop, w_err, w_e_dest, w_e_len, w_e_frame;
  logic r_live;
  state_t r_state;
  logic [BW-1:0] r_body;
  logic [NOC_ID_X_WIDTH-1:0] r_src_x;
  logic [NOC_ID_Y_WIDTH-1:0] r_src_y;
  assign bus.in_ready = r_live && (w_count < CW'(FIFO_DEPTH));
  assign w_push = bus.in_valid && bus.in_ready && !w_full;
  noc_sync_fifo #(.WIDTH(NOC_DATA_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(noc_clk),
    .rst(noc_rst),
    .push(w_push),
    .pop(w_pop),
    .din({bus.in_is_header, bus.in_is_tail, bus.in_flit}),
    .dout({w_hdr, w_tail, w_flit}),
    .full(w_full),
    .empty(w_empty),
    .count(w_count)
  );
  assign w_head_mk = mark_h(w_flit) == NOC_HEAD_H && mark_e(w_flit) == NOC_HEAD_E;
  assign w_tail_ok = mark_h(w_flit) == NOC_TAIL_H && mark_e(w_flit) == NOC_TAIL_E
                     && src_id(w_flit) == {r_src_x, r_src_y};
  assign w_dest_ok = dst_id(w_flit) == {X_ID, Y_ID};
  assign w_good_head = w_hdr && !w_tail && w_head_mk;
  assign w_body_full = r_body == BW'(MAX_BODY);
  // forward decision for the FIFO head; every other non-empty case except a header in BODY pops unforwarded
  always_comb
    w_fwd = !w_empty && (r_state == WAIT_HEAD ? w_good_head && w_dest_ok
                         : r_state == BODY && !w_hdr && (w_tail ? w_tail_ok : !w_body_full));
  assign w_err = !w_empty && !w_fwd && r_state != DROP;
  assign w_e_dest = w_err && r_state == WAIT_HEAD && w_good_head;
  assign w_e_len = w_err && r_state == BODY && !w_hdr && !w_tail;
  assign w_e_frame = w_err && !w_e_dest && !w_e_len;
  assign w_hs = w_fwd && bus.out_ready;
  assign w_eop = w_fwd && r_state == BODY && w_tail;
  assign w_pop = w_fwd ? bus.out_ready : !w_empty && !(r_state == BODY && w_hdr);
  assign bus.out_valid = w_fwd;
  assign bus.out_sop = w_fwd && r_state == WAIT_HEAD;
  assign bus.out_eop = w_eop;
  assign bus.out_flit = w_fwd ? w_flit : '0;
  assign bus.out_src_x = r_src_x;
  assign bus.out_src_y = r_src_y;
  // framing FSM, source latch, body length, saturating counters and sticky flags
  always_ff @(posedge noc_clk)
    if (noc_rst) begin
      r_live <= 1'b0;
      r_state <= WAIT_HEAD;
      r_body <= '0;
      r_src_x <= '0;
      r_src_y <= '0;
      pkt_count <= '0;
      err_count <= '0;
      err_dest <= 1'b0;
      err_frame <= 1'b0;
      err_len <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (!w_empty)
        case (r_state)
          WAIT_HEAD: r_state <= w_fwd ? (bus.out_ready ? BODY : WAIT_HEAD)
                                      : (w_hdr && !w_tail ? DROP : WAIT_HEAD);
          BODY:      r_state <= w_fwd ? (w_tail && bus.out_ready ? WAIT_HEAD : BODY)
                                      : (w_e_len ? DROP : WAIT_HEAD);
          default:   r_state <= w_tail ? WAIT_HEAD : DROP;
        endcase
      if (w_hs && r_state == WAIT_HEAD) begin
        {r_src_x, r_src_y} <= src_id(w_flit);
        r_body <= '0;
      end
      if (w_hs && r_state == BODY && !w_tail) r_body <= r_body + BW'(1);
      if (w_hs && w_eop) pkt_count <= pkt_count + 16'(pkt_count != 16'hFFFF);
      if (w_err) err_count <= err_count + 8'(err_count != 8'hFF);
      if (w_e_dest) err_dest <= 1'b1;
      if (w_e_frame) err_frame <= 1'b1;
      if (w_e_len) err_len <= 1'b1;
    end
endmodule

// File: doc/noc_eject_checker.md
Name: noc_eject_checker

Overview:
- Ejection stage between a router's local output port and the attached node/NI receive port.
- Buffers incoming flits in a small FIFO and checks packet framing: header/tail flags, head/tail marker fields, destination ID and body length.
- Forwards only well-formed packets addressed to this node, tagged with source coordinates. Drops malformed or misrouted packets.
- Keeps saturating packet and error counters and sticky error flags for testbench and debug visibility.

Parameters:
- X_ID, 0, this node's X coordinate (`Noc_ID_X_Width bits).
- Y_ID, 0, this node's Y coordinate (`Noc_ID_Y_Width bits).
- FIFO_DEPTH, 4, ingress FIFO entries; power of two, at least 2.
- MAX_BODY, 16, maximum data flits between header and tail.

Ports:
- noc_clk  in  1  single clock.
- noc_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  router flit valid.
- in_ready  out  1  FIFO can accept a flit.
- in_flit  in  `Noc_Data_Width  flit payload.
- in_is_header  in  1  flit is the header.
- in_is_tail  in  1  flit is the tail.
- out_valid  out  1  forwarded flit valid.
- out_ready  in  1  consumer accepts the flit.
- out_flit  out  `Noc_Data_Width  forwarded flit.
- out_sop  out  1  forwarded flit is the header.
- out_eop  out  1  forwarded flit is the tail.
- out_src_x  out  `Noc_ID_X_Width  source X of the current packet.
- out_src_y  out  `Noc_ID_Y_Width  source Y of the current packet.
- pkt_count  out  16  good packets delivered; saturates at 0xFFFF.
- err_count  out  8  dropped packets or aborted flits; saturates at 0xFF.
- err_dest  out  1  sticky: a header carried the wrong destination.
- err_frame  out  1  sticky: flag or marker framing violation.
- err_len  out  1  sticky: body exceeded MAX_BODY.

Behaviour:
- Reset (noc_rst high at a clock edge):
  - FIFO emptied; FSM to WAIT_HEAD.
  - All outputs 0, including in_ready, counters and sticky flags.
  - in_ready rises in the first cycle after reset deasserts.
  - Reset mid-packet discards the partial packet silently; err_count does not increment.
- Ingress:
  - Push when in_valid && in_ready.
  - in_ready = (occupancy < FIFO_DEPTH), registered-count based and independent of out_ready.
  - No bypass: a flit pushed at edge N is visible at the FIFO head in cycle N+1. Sustained throughput is 1 flit/cycle.
  - Push and pop in the same cycle is legal at any occupancy below full; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Header decode, applied to the FIFO head:
  - Head marker: flit[`Noc_Data_Width-1:`Noc_Point_H] must equal `Noc_Head_H (tail flits: `Noc_Tail_H).
  - End marker: flit[`Axi_Len_Point-1:`Noc_Point_E] must equal `Noc_Head_E (tail flits: `Noc_Tail_E).
  - Source ID field: flit[`Noc_Point_H-1:`Noc_Source_Point], X in the upper bits, Y in the lower bits.
  - Destination fields follow the source fields.
- FSM, evaluated only when the FIFO is non-empty; an empty FIFO holds state and drives out_valid=0:
  - WAIT_HEAD:
    - Head has is_header=1, is_tail=0, both head markers match, dest==(X_ID,Y_ID): present with out_sop=1; latch src X/Y and clear the body counter. On handshake go to BODY.
    - Dest mismatch only: pop without forwarding, set err_dest, err_count+1, go to DROP.
    - Any flag or marker error: pop, set err_frame, err_count+1. Go to DROP unless the flit had is_tail=1, in which case stay in WAIT_HEAD.
    - Non-header flit while in WAIT_HEAD: pop, set err_frame, err_count+1, stay.
  - BODY:
    - Data flit (is_header=0, is_tail=0): forward and increment the body count on handshake.
    - A data flit arriving with body count == MAX_BODY: pop, set err_len, err_count+1, deassert output, go to DROP.
    - Tail (is_tail=1) with both tail markers matching and source == latched source: forward with out_eop=1; on handshake pkt_count+1 and go to WAIT_HEAD.
    - Tail that fails any check: pop unforwarded, set err_frame, err_count+1, go to WAIT_HEAD.
    - Header arriving in BODY: err_frame, err_count+1. Do not pop; the flit is re-evaluated in WAIT_HEAD next cycle. The consumer sees no eop for the aborted packet.
  - DROP: pop every cycle unforwarded; on a flit with is_tail=1 go to WAIT_HEAD.
- Output is combinational from the FIFO head and FSM state; pop = out_valid&&out_ready, or an unconditional drop pop.
- out_flit/out_valid hold stable while out_valid && !out_ready.
- out_src_x/out_src_y hold their latched values until the next good header.
- Counters saturate; err_count counts one per drop event, not per dropped flit.

Decomposition:
- Shared Noc package/include (existing Noc_parameters.v) gains:
  - FSM state encodings WAIT_HEAD=0, BODY=1, DROP=2.
  - Field-slice macros for src/dest X/Y.
  - Marker compare constants.
- Sub-module noc_sync_fifo:
  - Parameterised width `Noc_Data_Width+2 and depth FIFO_DEPTH.
  - Synchronous active-high reset; full/empty/count outputs.
  - Reusable by other NI stages.

Test Plan:
- Good packet: node (1,2) sends header, data 0xA5A5..., tail to X_ID=3,Y_ID=0 with out_ready=1 -> 3 flits out on consecutive cycles, first arriving 1 cycle after push; sop on flit 1, eop on flit 3; out_src=(1,2); pkt_count=1; err_count=0.
- Misrouted: header dest (2,2) to node (3,0) -> no out_valid for all 3 flits; err_dest=1; err_count=1; the next good packet is delivered normally.
- Backpressure: out_ready=0 while pushing 6 flits with FIFO_DEPTH=4 -> in_ready drops after the 4th push; raising out_ready drains in order with no loss or duplication.
- Aborted packet: header, data, then a new header without a tail -> err_frame=1; err_count=1; the second packet is forwarded with sop; the first never shows eop.
- Length overflow: MAX_BODY=2, header + 3 data + tail -> 2 data flits forwarded, the rest dropped; err_len=1; pkt_count unchanged.
- Reset mid-packet: noc_rst for 1 cycle after the header is forwarded -> all outputs 0 and in_ready=0 during reset; the following full packet delivers with pkt_count=1.
